fifo_read_ctrl: RTL and testbench

Read-side controller for the async FIFO. It is the counterpart of the write-pointer logic and lives in the read clock domain. It takes the 2-flop-synchronized Gray write pointer, maintains the binary/Gray read pointer, generates the registered empty and almost-empty flags and an occupancy count, and drives the dual-port RAM read port. A two-entry output stage (output register plus skid) presents first-word-fall-through data to the consumer over a valid/ready handshake at full throughput.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_out_stage.sv | 74 +++++++
 rtl/fifo_read_ctrl.sv | 72 +++++++
 tb/tb_fifo_read_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray/binary pointer conversion, common to both clock domains.
package fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned MAX_PTR_W      = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Narrower pointers are zero-extended, so the upper zeros leave the low bits untouched.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = int'(MAX_PTR_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Two-entry first-word-fall-through output stage (output register plus skid) with valid/ready.
module fifo_out_stage
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            occupancy
);

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_next;
    logic                  skid_valid_next;
    logic [DATA_WIDTH-1:0] skid_data_next;
    logic                  drain;

    // Skid refills the output register first on a drain so word order is preserved.
    always_comb begin
        out_valid_next  = rd_valid;
        out_data_next   = rd_data;
        skid_valid_next = skid_valid;
        skid_data_next  = skid_data;
        drain           = rd_valid && rd_ready;

        if (drain) begin
            if (skid_valid) begin
                out_valid_next  = 1'b1;
                out_data_next   = skid_data;
                skid_valid_next = fetch_valid;
                if (fetch_valid) begin
                    skid_data_next = fetch_data;
                end
            end else begin
                out_valid_next = fetch_valid;
                if (fetch_valid) begin
                    out_data_next = fetch_data;
                end
            end
        end else if (fetch_valid) begin
            if (!rd_valid) begin
                out_valid_next = 1'b1;
                out_data_next  = fetch_data;
            end else begin
                skid_valid_next = 1'b1;
                skid_data_next  = fetch_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            rd_valid   <= out_valid_next;
            rd_data    <= out_data_next;
            skid_valid <= skid_valid_next;
            skid_data  <= skid_data_next;
        end
    end

    assign occupancy = 2'(rd_valid) + 2'(skid_valid);

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-domain controller: read pointer, empty/almost-empty flags, occupancy and RAM fetch.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  ren,
    input  logic [DATA_WIDTH-1:0] rdata_mem,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic             fetch_pending;
    logic [1:0]       stage_occ;
    logic [1:0]       slots_after;

    // Fetch only while the output stage plus the in-flight read leaves room for another word.
    always_comb begin
        slots_after  = stage_occ + 2'(fetch_pending) - 2'(rd_valid && rd_ready);
        ren          = !empty && (slots_after < 2'd2);
        rbin_next    = rbin + PTR_W'(ren);
        rgray_next   = PTR_W'(bin2gray(MAX_PTR_W'(rbin_next)));
        rd_count     = PTR_W'(gray2bin(MAX_PTR_W'(rq2_wptr))) - rbin;
        almost_empty = 32'(rd_count) <= AE_THRESH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin          <= '0;
            rptr          <= '0;
            empty         <= 1'b1;
            fetch_pending <= 1'b0;
        end else begin
            rbin          <= rbin_next;
            rptr          <= rgray_next;
            empty         <= (rgray_next == rq2_wptr);
            fetch_pending <= ren;
        end
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

    fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_pending),
        .fetch_data  (rdata_mem),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .occupancy   (stage_occ)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: RAM model, word-queue scoreboard and directed/random read traffic.
module tb_fifo_read_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] rq2_wptr;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [DW-1:0] rdata_mem;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_count;

    fifo_read_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AE_THRESH  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rq2_wptr     (rq2_wptr),
        .rptr         (rptr),
        .raddr        (raddr),
        .ren          (ren),
        .rdata_mem    (rdata_mem),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (ren) rdata_mem <= mem[raddr];
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    int            ren_cnt  = 0;
    logic [DW-1:0] q[$];
    logic [PW-1:0] wbin;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Write side: store a random word in the RAM, then advance the synchronized pointer.
    task automatic push();
        logic [DW-1:0] d;
        d = DW'($urandom);
        mem[wbin[AW-1:0]] = d;
        q.push_back(d);
        wbin = wbin + PW'(1);
        rq2_wptr = to_gray(wbin);
    endtask

    // Observe the coming edge (handshake, hold, ren) and advance to the next falling edge.
    task automatic tick();
        logic [DW-1:0] exp_d;
        #1;
        if (prev_stall) begin
            check("hold_valid", 32'(rd_valid), 1);
            check("hold_data", 32'(rd_data), 32'(prev_data));
        end
        if (rd_valid && rd_ready) begin
            if (q.size() == 0) begin
                check("pop_unexpected", 32'(rd_valid), 0);
            end else begin
                exp_d = q.pop_front();
                check("pop_data", 32'(rd_data), 32'(exp_d));
            end
        end
        if (ren) ren_cnt++;
        prev_stall = rd_valid && !rd_ready;
        prev_data  = rd_data;
        @(negedge clk);
    endtask

    task automatic drain_all();
        rd_ready = 1'b1;
        for (int i = 0; i < 300 && q.size() != 0; i++) tick();
        check("drain_done", q.size(), 0);
        tick();
    endtask

    initial begin
        int base;
        int pushed;
        logic [DW-1:0] head;

        rst        = 1'b1;
        rq2_wptr   = '0;
        rd_ready   = 1'b0;
        wbin       = '0;
        prev_stall = 1'b0;
        prev_data  = '0;

        @(negedge clk);
        check("rst_rptr", 32'(rptr), 0);
        check("rst_raddr", 32'(raddr), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        check("rst_count", 32'(rd_count), 0);
        check("rst_ren", 32'(ren), 0);
        check("rst_ae", 32'(almost_empty), 1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ren", 32'(ren), 0);
        end

        // Single word through the whole latency chain
        push();
        tick();
        check("sw_empty_fall", 32'(empty), 0);
        check("sw_ren", 32'(ren), 1);
        check("sw_raddr", 32'(raddr), 0);
        check("sw_count", 32'(rd_count), 1);
        tick();
        check("sw_rptr", 32'(rptr), 32'(7'b0000001));
        check("sw_empty_rise", 32'(empty), 1);
        check("sw_valid_wait", 32'(rd_valid), 0);
        check("sw_ren_off", 32'(ren), 0);
        check("sw_count0", 32'(rd_count), 0);
        tick();
        head = q[0];
        check("sw_valid", 32'(rd_valid), 1);
        check("sw_data", 32'(rd_data), 32'(head));
        rd_ready = 1'b1;
        tick();
        check("sw_valid_gone", 32'(rd_valid), 0);
        check("sw_popped", q.size(), 0);

        // Ten words streamed at full rate
        base = ren_cnt;
        for (int i = 0; i < 10; i++) push();
        for (int i = 0; i < 10 && !rd_valid; i++) tick();
        check("stream_start", 32'(rd_valid), 1);
        for (int i = 0; i < 10; i++) begin
            check("stream_valid", 32'(rd_valid), 1);
            tick();
        end
        check("stream_end_valid", 32'(rd_valid), 0);
        check("stream_ren_pulses", ren_cnt - base, 10);
        check("stream_popped", q.size(), 0);

        // Backpressure: only two words may be fetched
        rd_ready = 1'b0;
        base = ren_cnt;
        for (int i = 0; i < 5; i++) push();
        for (int i = 0; i < 8; i++) tick();
        head = q[0];
        check("bp_ren_pulses", ren_cnt - base, 2);
        check("bp_valid", 32'(rd_valid), 1);
        check("bp_head", 32'(rd_data), 32'(head));
        check("bp_count", 32'(rd_count), 3);
        drain_all();
        check("bp_total_ren", ren_cnt - base, 5);

        // Almost-empty threshold
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) push();
        for (int i = 0; i < 8; i++) tick();
        check("ae_count6", 32'(rd_count), 6);
        check("ae_off6", 32'(almost_empty), 0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("ae_count5", 32'(rd_count), 5);
        check("ae_off5", 32'(almost_empty), 0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("ae_count4", 32'(rd_count), 4);
        check("ae_on4", 32'(almost_empty), 1);
        for (int i = 0; i < 3; i++) push();
        tick();
        check("ae_count7", 32'(rd_count), 7);
        check("ae_off7", 32'(almost_empty), 0);
        drain_all();

        // Random writes and random consumer backpressure
        for (int i = 0; i < 400; i++) begin
            rd_ready = ($urandom_range(0, 3) != 0);
            if (q.size() < 56 && $urandom_range(0, 2) != 0) push();
            tick();
        end
        drain_all();
        check("rnd_empty", 32'(empty), 1);
        check("rnd_count", 32'(rd_count), 0);
        check("rnd_rptr", 32'(rptr), 32'(to_gray(wbin)));
        check("rnd_raddr", 32'(raddr), 32'(wbin[AW-1:0]));

        // 130 words across pointer wrap with no gap in rd_valid
        rd_ready = 1'b0;
        for (int i = 0; i < 50; i++) push();
        for (int i = 0; i < 6; i++) tick();
        rd_ready = 1'b1;
        pushed = 0;
        for (int i = 0; i < 130; i++) begin
            check("wrap_valid", 32'(rd_valid), 1);
            if (q.size() < 56 && pushed < 80) begin
                push();
                pushed++;
            end
            tick();
        end
        check("wrap_popped", q.size(), 0);
        tick();
        check("wrap_empty", 32'(empty), 1);
        check("wrap_rptr", 32'(rptr), 32'(to_gray(wbin)));
        check("wrap_raddr", 32'(raddr), 32'(wbin[AW-1:0]));
        check("wrap_count", 32'(rd_count), 0);
        check("wrap_valid_gone", 32'(rd_valid), 0);

        // Asynchronous reset while data is held
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) push();
        for (int i = 0; i < 6; i++) tick();
        check("mr_valid_before", 32'(rd_valid), 1);
        #2;
        rst        = 1'b1;
        rq2_wptr   = '0;
        wbin       = '0;
        q.delete();
        prev_stall = 1'b0;
        #1;
        check("mr_rptr", 32'(rptr), 0);
        check("mr_raddr", 32'(raddr), 0);
        check("mr_empty", 32'(empty), 1);
        check("mr_valid", 32'(rd_valid), 0);
        check("mr_count", 32'(rd_count), 0);
        check("mr_ren", 32'(ren), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_idle_ren", 32'(ren), 0);
            check("mr_idle_valid", 32'(rd_valid), 0);
        end
        push();
        for (int i = 0; i < 3; i++) tick();
        head = q[0];
        check("mr_again_valid", 32'(rd_valid), 1);
        check("mr_again_data", 32'(rd_data), 32'(head));
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
